// File: rtl/cfg_seq_pkg.sv
// Shared types and entry decoding for the camera configuration sequencer.
// Build option: CFG_RETRY_EN (NACK retries in cfg_sequencer).
package cfg_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WRITE,
        S_DELAY,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE,
        OP_NOP,
        OP_DELAY,
        OP_END
    } op_t;

    // All-ones of a field; the register field at this value marks END/DELAY/NOP.
    function automatic logic [63:0] field_mask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] entry_reg(input logic [63:0] e,
                                              input int reg_w,
                                              input int data_w);
        return (e >> data_w) & field_mask(reg_w);
    endfunction

    function automatic logic [63:0] entry_data(input logic [63:0] e,
                                               input int data_w);
        return e & field_mask(data_w);
    endfunction

    function automatic op_t classify(input logic [63:0] r,
                                     input logic [63:0] d,
                                     input int reg_w,
                                     input int data_w);
        op_t op;
        logic mark;
        op = OP_WRITE;
        mark = (r == field_mask(reg_w));
        unique case (1'b1)
            !mark: op = OP_WRITE;
            mark && (d == field_mask(data_w)): op = OP_END;
            mark && (d == '0): op = OP_NOP;
            mark && (d != '0) && (d != field_mask(data_w)): op = OP_DELAY;
            default: op = OP_WRITE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter for in-table delay entries.
// Holds at zero; o_expired is high while the count is zero.
module cfg_delay_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= i_load_val;
        end else if (i_en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign o_expired = (cnt == '0);

endmodule

// File: rtl/cfg_sequencer.sv
// Camera configuration sequencer: walks the config ROM and issues bus writes.
// Build option: CFG_RETRY_EN enables up to MAX_RETRY re-requests after a NACK.
module cfg_sequencer
    import cfg_seq_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int REG_W          = 8,
    parameter int DATA_W         = 8,
    parameter int DELAY_UNIT_CYC = 25000,
    parameter int MAX_RETRY      = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_start,
    output logic [ADDR_W-1:0]       o_rom_addr,
    input  logic [REG_W+DATA_W-1:0] i_rom_data,
    output logic                    o_wr_req,
    output logic [REG_W-1:0]        o_wr_reg,
    output logic [DATA_W-1:0]       o_wr_data,
    input  logic                    i_wr_done,
    input  logic                    i_wr_nack,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic [ADDR_W-1:0]       o_err_idx
);

    localparam longint DLY_MAX =
        longint'(DELAY_UNIT_CYC) * ((longint'(1) << DATA_W) - 1);
    localparam int CNT_W = $clog2(DLY_MAX + 1);

    state_t            state;
    op_t               op;
    logic [REG_W-1:0]  ent_reg;
    logic [DATA_W-1:0] ent_data;
    logic [CNT_W-1:0]  dly_load;
    logic              dly_expired;
    logic              adv;
    logic              fin;
    logic              last_idx;

`ifdef CFG_RETRY_EN
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RTY_W-1:0] retry_cnt;
`endif

    assign ent_reg  = REG_W'(entry_reg(64'(i_rom_data), REG_W, DATA_W));
    assign ent_data = DATA_W'(entry_data(64'(i_rom_data), DATA_W));
    assign op       = classify(64'(ent_reg), 64'(ent_data), REG_W, DATA_W);
    assign dly_load = CNT_W'(64'(ent_data) * 64'(DELAY_UNIT_CYC) - 64'd1);
    assign last_idx = &o_rom_addr;
    assign fin      = (state == S_DECODE) && (op == OP_END);

    always_comb begin
        adv = 1'b0;
        unique case (state)
            S_DECODE: adv = (op == OP_NOP);
            S_WRITE:  adv = o_wr_req && i_wr_done && !i_wr_nack;
            S_DELAY:  adv = dly_expired;
            default:  adv = 1'b0;
        endcase
    end

    cfg_delay_timer #(.W(CNT_W)) u_timer (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_load     ((state == S_DECODE) && (op == OP_DELAY)),
        .i_load_val (dly_load),
        .i_en       (state == S_DELAY),
        .o_expired  (dly_expired)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state      <= S_IDLE;
            o_rom_addr <= '0;
            o_wr_req   <= 1'b0;
            o_wr_reg   <= '0;
            o_wr_data  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_err_idx  <= '0;
`ifdef CFG_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_start) begin
                        state      <= S_FETCH;
                        o_rom_addr <= '0;
                        o_done     <= 1'b0;
                        o_err      <= 1'b0;
                        o_err_idx  <= '0;
                        o_busy     <= 1'b1;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
`ifdef CFG_RETRY_EN
                    retry_cnt <= '0;
`endif
                    if (op == OP_DELAY) begin
                        state <= S_DELAY;
                    end else if (op == OP_WRITE) begin
                        state     <= S_WRITE;
                        o_wr_req  <= 1'b1;
                        o_wr_reg  <= ent_reg;
                        o_wr_data <= ent_data;
                    end
                end
                S_WRITE: begin
                    if (!o_wr_req) begin
                        // Re-request after the one-cycle retry gap.
                        o_wr_req <= 1'b1;
                    end else if (i_wr_done) begin
                        o_wr_req <= 1'b0;
                        if (i_wr_nack) begin
`ifdef CFG_RETRY_EN
                            if (int'(retry_cnt) < MAX_RETRY) begin
                                retry_cnt <= retry_cnt + RTY_W'(1);
                            end else begin
                                state     <= S_ERR;
                                o_err     <= 1'b1;
                                o_err_idx <= o_rom_addr;
                                o_busy    <= 1'b0;
                            end
`else
                            state     <= S_ERR;
                            o_err     <= 1'b1;
                            o_err_idx <= o_rom_addr;
                            o_busy    <= 1'b0;
`endif
                        end
                    end
                end
                S_DELAY: begin
                end
                default: state <= S_IDLE;
            endcase

            // The last ROM slot ends the table instead of wrapping.
            if (fin || (adv && last_idx)) begin
                state  <= S_DONE;
                o_done <= 1'b1;
                o_busy <= 1'b0;
            end else if (adv) begin
                o_rom_addr <= o_rom_addr + ADDR_W'(1);
                state      <= S_FETCH;
            end
        end
    end

endmodule

// File: doc/cfg_sequencer.md
Name: cfg_sequencer

Overview:
- Parametrised camera-configuration sequencer. Walks an external registered configuration ROM entry by entry and issues register writes to the serial-bus (SCCB/I2C) master through a request/done handshake.
- Executes in-table delay and end opcodes, and reports completion, busy and error status.
- Sits between the configuration ROM and the serial-bus master in the camera front end.
- Register-address width, data width, ROM depth and delay timebase are generic, so one block serves 8-bit and 16-bit-address sensors.

Parameters:
- ADDR_W, 8: ROM index width; the ROM holds at most 2^ADDR_W entries.
- REG_W, 8: sensor register-address field width.
- DATA_W, 8: register data field width.
- DELAY_UNIT_CYC, 25000: i_clk cycles per delay unit (1 ms at 25 MHz).
- MAX_RETRY, 3: NACK retries per write. Used only with CFG_RETRY_EN.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle pulse that starts a sequence from index 0. Ignored unless IDLE, DONE or ERR.
- o_rom_addr  out  ADDR_W  ROM index.
- i_rom_data  in  REG_W+DATA_W  entry; {reg, data}; valid 1 cycle after o_rom_addr changes.
- o_wr_req  out  1  write request to the bus master; held until i_wr_done.
- o_wr_reg  out  REG_W  register address; stable while o_wr_req is high.
- o_wr_data  out  DATA_W  register data; stable while o_wr_req is high.
- i_wr_done  in  1  one-cycle pulse: bus transaction finished.
- i_wr_nack  in  1  qualified by i_wr_done: the slave did not acknowledge.
- o_busy  out  1  high while the sequence runs.
- o_done  out  1  level; high after the end opcode, cleared by i_start.
- o_err  out  1  level; high after an unrecoverable NACK, cleared by i_start.
- o_err_idx  out  ADDR_W  ROM index of the failing entry.

Behaviour:
- Reset: state IDLE; all outputs 0. A reset mid-sequence or mid-delay aborts immediately with no further requests.
- States: IDLE, FETCH, DECODE, WRITE, DELAY, DONE, ERR.
- IDLE/DONE/ERR on i_start: o_rom_addr<=0, clear o_done/o_err/o_err_idx, go to FETCH. o_busy=1 in FETCH, DECODE, WRITE and DELAY only.
- FETCH: wait one cycle for ROM latency, then go to DECODE.
- DECODE: split i_rom_data into reg (upper REG_W bits) and data (lower DATA_W bits).
  - reg all-ones and data all-ones: END; go to DONE and set o_done=1.
  - reg all-ones and data == 0: no-op; advance.
  - reg all-ones, other data: go to DELAY; load counter = data*DELAY_UNIT_CYC-1.
  - otherwise: latch o_wr_reg/o_wr_data, raise o_wr_req and go to WRITE.
- WRITE: hold o_wr_req and its fields until i_wr_done.
  - i_wr_done without NACK: drop o_wr_req in the same edge and advance.
  - i_wr_done with NACK (no retry feature): go to ERR; o_err=1; o_err_idx = current index.
- DELAY: decrement every cycle; at 0, advance. A delay entry with data=N lasts N*DELAY_UNIT_CYC cycles.
- Advance: if o_rom_addr == 2^ADDR_W-1, treat as END (go to DONE) without wrapping; otherwise increment and go to FETCH.
- Timing: minimum cost per entry is 2 cycles (FETCH, DECODE) plus the write or delay time.
- o_wr_req is never asserted outside WRITE. An i_wr_done pulse outside WRITE is ignored.
- Delay counter width: clog2(DELAY_UNIT_CYC*(2^DATA_W-1)+1).

Optional Feature:
- Macro: CFG_RETRY_EN.
- When defined: on NACK, drop o_wr_req for one cycle, then re-request the same entry; at most MAX_RETRY retries, then ERR. The retry counter resets per entry.
- When undefined: the first NACK goes straight to ERR, and the retry counter is not synthesised.

Decomposition:
- Package cfg_seq_pkg: state enum; the END and DELAY marker constants, derived from REG_W/DATA_W all-ones; the entry-field slicing functions.
- One sub-module, cfg_delay_timer: load/count/expire down-counter parametrised by width. Used by the DELAY state.

Test Plan:
- ROM {0x12_80, 0x11_00, 0xFF_FF}, ack all: pulse i_start -> exactly 2 requests (0x12/0x80, 0x11/0x00); o_done=1 at index 2; o_busy low afterwards.
- ROM {0xFF_02, 0x0C_04, 0xFF_FF} with DELAY_UNIT_CYC=10: gap from leaving DECODE at index 0 to the request for 0x0C is exactly 20 cycles of DELAY plus 2 (FETCH+DECODE).
- NACK on index 3, retry undefined: o_err=1, o_err_idx=3, no request for index 4. A later i_start restarts at index 0 with o_err cleared.
- CFG_RETRY_EN, MAX_RETRY=3, NACK twice then ack: 3 requests for the same entry, then advance. Four NACKs: ERR after the 4th.
- Bus master delays i_wr_done by 500 cycles: o_wr_req, o_wr_reg and o_wr_data stay stable throughout. A reset asserted mid-DELAY gives IDLE and all outputs 0 on the next cycle.
- ADDR_W=2, ROM with no END entry: after index 3 completes, o_done=1 and o_rom_addr stays at 3 (no wrap).
